// File: rtl/id_scoreboard.sv
// id_scoreboard: decode-stage register scoreboard and serialisation sequencer.
//   Tracks pending register writes per architectural register (r0 never
//   tracked), stalls decode on RAW hazards or counter saturation, and walks
//   serialising instructions through DRAIN -> BUBBLE -> SYSP -> RELEASE.
// Ports:
//   CLK, RESET (async, active low)
//   issue_*   : decode-side instruction under consideration
//   wb_valid/wb_reg : retire of one pending register write
//   flush     : squash all in-flight tracking, FSM back to IDLE
//   stall, issue_fire (comb); want_freeze, SYS, inflight, wb_err (registered)
// Optional feature macro: SB_WB_BYPASS_EN
//   When defined, a source being retired this cycle with a count of 1 is
//   treated as ready (write-through register file read).

module id_sb_lane #(
  parameter int CNT_W = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             flush,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt_q,
  output logic [CNT_W-1:0] cnt_d,
  output logic             under
);
  always_comb begin
    cnt_d = cnt_q;
    under = 1'b0;
    if (flush) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      // decode never fires into a saturated counter; hold as a safety net
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc) begin
      if (cnt_q == '0) under = 1'b1;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

module id_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int CNT_W    = 2,
  parameter int BUBBLES  = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   issue_valid,
  input  logic [REG_W-1:0]       issue_rs,
  input  logic [REG_W-1:0]       issue_rt,
  input  logic                   issue_use_rs,
  input  logic                   issue_use_rt,
  input  logic                   issue_wr,
  input  logic [REG_W-1:0]       issue_rd,
  input  logic                   issue_serialize,
  input  logic                   issue_sys,
  input  logic                   wb_valid,
  input  logic [REG_W-1:0]       wb_reg,
  input  logic                   flush,
  output logic                   stall,
  output logic                   issue_fire,
  output logic                   want_freeze,
  output logic                   SYS,
  output logic [REG_W+CNT_W-1:0] inflight,
  output logic                   wb_err
);
  localparam int NSLOT = 2**REG_W;

  typedef enum logic [2:0] {IDLE, DRAIN, BUBBLE, SYSP, RELEASE} state_t;

  state_t state_q, state_d;
  logic [3:0] bub_q, bub_d;

  logic [NSLOT-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NSLOT-1:0]            under;
  logic                        fire_wr;
  logic                        rs_busy, rt_busy, raw, sat, stall_c;
  logic [REG_W+CNT_W-1:0]      sum_d;

  assign fire_wr = issue_fire & issue_wr & (issue_rd != '0);

  // Index space is padded to 2^REG_W so any register field is a legal index;
  // r0 and slots beyond NUM_REGS read as permanently idle.
  for (genvar g = 0; g < NSLOT; g++) begin : g_lane
    if (g == 0 || g >= NUM_REGS) begin : g_off
      assign cnt_q[g] = '0;
      assign cnt_d[g] = '0;
      assign under[g] = 1'b0;
    end else begin : g_on
      id_sb_lane #(.CNT_W(CNT_W)) u_lane (
        .CLK   (CLK),
        .RESET (RESET),
        .flush (flush),
        .inc   (fire_wr & (issue_rd == REG_W'(g))),
        .dec   (wb_valid & (wb_reg == REG_W'(g))),
        .cnt_q (cnt_q[g]),
        .cnt_d (cnt_d[g]),
        .under (under[g])
      );
    end
  end

  // Hazards
  always_comb begin
    rs_busy = issue_use_rs & (issue_rs != '0) & (cnt_q[issue_rs] != '0);
    rt_busy = issue_use_rt & (issue_rt != '0) & (cnt_q[issue_rt] != '0);
`ifdef SB_WB_BYPASS_EN
    if (wb_valid && wb_reg == issue_rs && cnt_q[issue_rs] == CNT_W'(1)) rs_busy = 1'b0;
    if (wb_valid && wb_reg == issue_rt && cnt_q[issue_rt] == CNT_W'(1)) rt_busy = 1'b0;
`endif
    raw = rs_busy | rt_busy;
    sat = issue_wr & (issue_rd != '0) & (cnt_q[issue_rd] == {CNT_W{1'b1}});
  end

  // Serialisation FSM and issue control
  always_comb begin
    state_d = state_q;
    bub_d   = bub_q;
    stall_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_c = issue_valid & (raw | sat | issue_serialize);
        if (issue_valid && issue_serialize) state_d = DRAIN;
      end
      DRAIN: begin
        stall_c = issue_valid;
        if (inflight == '0) begin
          if (BUBBLES == 0) begin
            state_d = SYSP;
          end else begin
            state_d = BUBBLE;
            bub_d   = 4'(BUBBLES);
          end
        end
      end
      BUBBLE: begin
        stall_c = issue_valid;
        bub_d   = bub_q - 4'd1;
        if (bub_q <= 4'd1) state_d = SYSP;
      end
      SYSP: begin
        stall_c = issue_valid;
        state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;  // the held serialising instruction fires here
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      bub_d   = '0;
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  assign stall      = stall_c & RESET;
  assign issue_fire = issue_valid & ~stall_c & ~flush & RESET;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NSLOT; i++) sum_d = sum_d + {{REG_W{1'b0}}, cnt_d[i]};
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      bub_q       <= '0;
      SYS         <= 1'b0;
      want_freeze <= 1'b0;
      inflight    <= '0;
      wb_err      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bub_q       <= bub_d;
      SYS         <= (state_d == SYSP) & issue_sys;
      want_freeze <= (state_d == DRAIN) | (state_d == BUBBLE) | (state_d == SYSP);
      inflight    <= sum_d;
      wb_err      <= wb_err | (|under);
    end
  end
endmodule

// File: tb/tb_id_scoreboard.sv
module tb_id_scoreboard;
  logic       CLK, RESET;
  logic       issue_valid, iv0;
  logic [4:0] rs, rt, rd, wb_reg;
  logic       use_rs, use_rt, wr, ser, sys, wb_valid, flush;
  logic       stall, fire, wf, sysp, err;
  logic [6:0] infl;
  logic       stall0, fire0, wf0, sys0, err0;
  logic [6:0] infl0;

  int n_chk = 0;
  int n_bad = 0;
  int sys_cnt;
  logic [4:0] fr [4] = '{5'd1, 5'd2, 5'd4, 5'd6};

  // main instance, BUBBLES=2
  id_scoreboard #(.BUBBLES(2)) u_dut (
    .CLK(CLK), .RESET(RESET), .issue_valid(issue_valid),
    .issue_rs(rs), .issue_rt(rt), .issue_use_rs(use_rs), .issue_use_rt(use_rt),
    .issue_wr(wr), .issue_rd(rd), .issue_serialize(ser), .issue_sys(sys),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush),
    .stall(stall), .issue_fire(fire), .want_freeze(wf), .SYS(sysp),
    .inflight(infl), .wb_err(err)
  );

  // second instance, BUBBLES=0, own issue_valid
  id_scoreboard #(.BUBBLES(0)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .issue_valid(iv0),
    .issue_rs(rs), .issue_rt(rt), .issue_use_rs(use_rs), .issue_use_rt(use_rt),
    .issue_wr(wr), .issue_rd(rd), .issue_serialize(ser), .issue_sys(sys),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush),
    .stall(stall0), .issue_fire(fire0), .want_freeze(wf0), .SYS(sys0),
    .inflight(infl0), .wb_err(err0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic clr();
    issue_valid = 0; iv0 = 0; rs = 0; rt = 0; rd = 0; use_rs = 0; use_rt = 0;
    wr = 0; ser = 0; sys = 0; wb_valid = 0; wb_reg = 0; flush = 0;
  endtask

  initial begin
    RESET = 0; clr();
    #12;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_fire",  32'(fire),  0);
    chk("rst_wf",    32'(wf),    0);
    chk("rst_sys",   32'(sysp),  0);
    chk("rst_infl",  32'(infl),  0);
    chk("rst_err",   32'(err),   0);
    @(negedge CLK); RESET = 1; tick();

    // RAW stall on r5
    clr(); issue_valid = 1; wr = 1; rd = 5; smp(); chk("raw_wr_fire", 32'(fire), 1); tick();
    clr(); issue_valid = 1; use_rs = 1; rs = 5;
    smp(); chk("raw_stall1", 32'(stall), 1); chk("raw_infl1", 32'(infl), 1); tick();
    smp(); chk("raw_stall2", 32'(stall), 1); tick();
    wb_valid = 1; wb_reg = 5; smp();
`ifdef SB_WB_BYPASS_EN
    chk("raw_bypass_fire", 32'(fire), 1); tick();
    wb_valid = 0; issue_valid = 0; smp(); chk("raw_infl0", 32'(infl), 0); tick();
`else
    chk("raw_stall_wb", 32'(stall), 1); tick();
    wb_valid = 0; smp(); chk("raw_fire_after", 32'(fire), 1); chk("raw_infl0", 32'(infl), 0); tick();
`endif

    // saturation on r7
    for (int k = 0; k < 3; k++) begin
      clr(); issue_valid = 1; wr = 1; rd = 7; smp(); chk("sat_fill", 32'(fire), 1); tick();
    end
    smp(); chk("sat_stall", 32'(stall), 1); chk("sat_infl3", 32'(infl), 3); tick();
    wb_valid = 1; wb_reg = 7;
    smp(); chk("sat_stall_wb", 32'(stall), 1); chk("sat_infl3b", 32'(infl), 3); tick();
    wb_valid = 0; smp(); chk("sat_release", 32'(fire), 1); tick();
    clr(); smp(); chk("sat_infl_after", 32'(infl), 3);
    wb_valid = 1; wb_reg = 7; tick(); tick(); tick();
    clr(); smp(); chk("sat_drained", 32'(infl), 0); chk("sat_noerr", 32'(err), 0); tick();

    // serialise with SYS, two writes in flight
    clr(); issue_valid = 1; wr = 1; rd = 1; tick(); rd = 2; tick();
    clr(); issue_valid = 1; ser = 1; sys = 1; wr = 1; rd = 3;
    smp(); chk("ser_c0_stall", 32'(stall), 1); chk("ser_c0_wf", 32'(wf), 0); tick();
    sys_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      wb_valid = (c == 3 || c == 5);
      wb_reg = (c == 3) ? 5'd1 : 5'd2;
      smp();
      if (sysp) sys_cnt++;
      chk("ser_wf", 32'(wf), (c <= 9) ? 1 : 0);
      if (c == 6) chk("ser_drain_empty", 32'(infl), 0);
      if (c == 7 || c == 8) begin
        chk("ser_bubble_sys", 32'(sysp), 0);
        chk("ser_bubble_stall", 32'(stall), 1);
      end
      if (c == 9) chk("ser_sysp", 32'(sysp), 1);
      if (c == 10) begin
        chk("ser_rel_fire", 32'(fire), 1);
        chk("ser_rel_stall", 32'(stall), 0);
      end
      tick();
    end
    clr(); smp();
    if (sysp) sys_cnt++;
    chk("ser_sys_once", sys_cnt, 1);
    chk("ser_idle_wf", 32'(wf), 0);
    chk("ser_rd_counted", 32'(infl), 1);
    wb_valid = 1; wb_reg = 3; tick();
    clr(); tick();

    // LL/SC on BUBBLES=0 instance, no SYS
    clr(); iv0 = 1; ser = 1; sys = 0; smp(); chk("ll_c0_stall", 32'(stall0), 1); tick();
    smp(); chk("ll_drain_wf", 32'(wf0), 1); chk("ll_drain_sys", 32'(sys0), 0); tick();
    smp(); chk("ll_sysp_wf", 32'(wf0), 1); chk("ll_sysp_sys", 32'(sys0), 0); tick();
    smp(); chk("ll_rel_wf", 32'(wf0), 0); chk("ll_rel_fire", 32'(fire0), 1); chk("ll_rel_sys", 32'(sys0), 0); tick();
    clr(); smp(); chk("ll_idle_wf", 32'(wf0), 0); tick();

    // flush with 4 pending writes
    for (int k = 0; k < 4; k++) begin
      clr(); issue_valid = 1; wr = 1; rd = fr[k]; tick();
    end
    clr(); flush = 1; issue_valid = 1; wr = 1; rd = 8;
    smp(); chk("fl_infl4", 32'(infl), 4); chk("fl_nofire", 32'(fire), 0); tick();
    clr(); smp(); chk("fl_infl0", 32'(infl), 0); chk("fl_wf0", 32'(wf), 0); tick();
    // flush during BUBBLE
    clr(); issue_valid = 1; ser = 1; sys = 1; tick();
    tick();
    clr(); flush = 1; smp(); chk("fl_bubble_wf", 32'(wf), 1); tick();
    clr(); issue_valid = 1; smp();
    chk("fl_idle_wf", 32'(wf), 0); chk("fl_idle_fire", 32'(fire), 1); chk("fl_nosys1", 32'(sysp), 0); tick();
    clr(); smp(); chk("fl_nosys2", 32'(sysp), 0); tick();

    // wb error and reset mid-DRAIN
    clr(); wb_valid = 1; wb_reg = 9; tick();
    clr(); smp(); chk("err_set", 32'(err), 1); tick();
    smp(); chk("err_sticky", 32'(err), 1); tick();
    clr(); issue_valid = 1; wr = 1; rd = 10; tick();
    clr(); issue_valid = 1; ser = 1; sys = 1; tick();
    smp(); chk("rst_mid_drain_wf", 32'(wf), 1);
    #1 RESET = 0;
    #1;
    chk("arst_stall", 32'(stall), 0);
    chk("arst_fire",  32'(fire),  0);
    chk("arst_wf",    32'(wf),    0);
    chk("arst_sys",   32'(sysp),  0);
    chk("arst_infl",  32'(infl),  0);
    chk("arst_err",   32'(err),   0);
    clr();
    @(negedge CLK); RESET = 1; tick();
    smp(); chk("post_rst_wf", 32'(wf), 0); chk("post_rst_infl", 32'(infl), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
